// File: rtl/timer_delay_scheduler.sv
// rtl/timer_delay_scheduler.sv - two-channel delay scheduler that programs a shared interval timer
module timer_delay_scheduler #(
  parameter int unsigned DELAY_MIN = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  req,
  input  logic [31:0] req_delay0,
  input  logic [31:0] req_delay1,
  input  logic [1:0]  cancel,
  output logic [1:0]  done,
  output logic [1:0]  aborted,
  output logic [1:0]  rejected,
  output logic        busy,
  output logic [2:0]  tmr_address,
  output logic        tmr_chipselect,
  output logic        tmr_write_n,
  output logic [15:0] tmr_writedata,
  input  logic        tmr_irq
);

  typedef enum logic [2:0] {IDLE, STOP, PER_L, PER_H, CLR, START, WAIT, ACK} state_t;

  localparam logic [31:0] DMIN = 32'(DELAY_MIN);

  state_t      state;
  state_t      state_next;
  logic        active;
  logic        prio;
  logic        cancelling;
  logic [1:0]  pending;
  logic [31:0] delay [2];
  logic [31:0] req_delay [2];
  logic [31:0] period;
  logic [1:0]  cancel_ok;
  logic [1:0]  eligible;
  logic        grant;
  logic        grant_ch;

  assign req_delay[0] = req_delay0;
  assign req_delay[1] = req_delay1;
  assign busy         = (state != IDLE);
  assign period       = delay[active] - 32'd1;

  // The active channel can only be cancelled through the WAIT path.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      cancel_ok[i] = cancel[i] & pending[i] & ~(busy & (active == 1'(i)));
    end
  end

  assign eligible = pending & ~cancel_ok;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next     = state;
    grant          = 1'b0;
    grant_ch       = prio;
    tmr_chipselect = 1'b0;
    tmr_write_n    = 1'b1;
    tmr_address    = 3'd0;
    tmr_writedata  = 16'h0000;
    case (state)
      IDLE: begin
        if (|eligible) begin
          grant      = 1'b1;
          grant_ch   = eligible[prio] ? prio : ~prio;
          state_next = STOP;
        end
      end
      STOP: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = 3'd1;
        tmr_writedata  = 16'h0008;
        state_next     = cancelling ? ACK : PER_L;
      end
      PER_L: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = 3'd2;
        tmr_writedata  = period[15:0];
        state_next     = PER_H;
      end
      PER_H: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = 3'd3;
        tmr_writedata  = period[31:16];
        state_next     = CLR;
      end
      CLR: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = 3'd0;
        tmr_writedata  = 16'h0000;
        state_next     = START;
      end
      START: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = 3'd1;
        tmr_writedata  = 16'h0005;
        state_next     = WAIT;
      end
      WAIT: begin
        // A timeout in the same cycle as a cancel completes normally.
        if (tmr_irq) begin
          state_next = ACK;
        end else if (cancel[active]) begin
          state_next = STOP;
        end
      end
      ACK: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = 3'd0;
        tmr_writedata  = 16'h0000;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active     <= 1'b0;
      prio       <= 1'b0;
      cancelling <= 1'b0;
    end else begin
      if (grant) begin
        active     <= grant_ch;
        prio       <= ~grant_ch;
        cancelling <= 1'b0;
      end
      if (state == WAIT && !tmr_irq && cancel[active]) begin
        cancelling <= 1'b1;
      end
      if (state == ACK) begin
        cancelling <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending  <= 2'b00;
      delay[0] <= 32'd0;
      delay[1] <= 32'd0;
      done     <= 2'b00;
      aborted  <= 2'b00;
      rejected <= 2'b00;
    end else begin
      done     <= 2'b00;
      aborted  <= 2'b00;
      rejected <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        if (state == ACK && active == 1'(i)) begin
          pending[i] <= 1'b0;
          if (cancelling) begin
            aborted[i] <= 1'b1;
          end else begin
            done[i] <= 1'b1;
          end
        end else if (cancel_ok[i]) begin
          pending[i] <= 1'b0;
          aborted[i] <= 1'b1;
        end
        if (req[i]) begin
          if (!pending[i]) begin
            pending[i] <= 1'b1;
            delay[i]   <= (req_delay[i] < DMIN) ? DMIN : req_delay[i];
          end else begin
            rejected[i] <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: doc/timer_delay_scheduler.md
TIMER_DELAY_SCHEDULER -- requirements
Module: timer_delay_scheduler

Interface
REQ-001 Parameter: DELAY_MIN, default 1, minimum delay in timer ticks; smaller requested delays SHALL be clamped up to it.
REQ-002 clk  input  1  system clock; all logic SHALL be rising-edge clocked.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  2  per-channel one-cycle request pulse.
REQ-005 req_delay0 / req_delay1  input  32 each  requested delay in ticks, sampled with req[0] / req[1].
REQ-006 cancel  input  2  per-channel one-cycle cancel pulse.
REQ-007 done / aborted / rejected  output  2 each  per-channel one-cycle completion, cancellation and refusal pulses.
REQ-008 busy  output  1  high whenever the FSM is not in IDLE.
REQ-009 tmr_address 3, tmr_chipselect 1, tmr_write_n 1, tmr_writedata 16  outputs  timer slave write port; single-cycle writes, no wait states.
REQ-010 tmr_irq  input  1  level timeout interrupt from the timer slave.

Function
REQ-011 Each channel SHALL keep a pending bit and a 32-bit delay register; req[i] with pending[i]=0 sets pending and captures max(req_delay_i, DELAY_MIN).
REQ-012 req[i] with pending[i]=1 SHALL be ignored and pulse rejected[i] the next cycle; a req[i] arriving in the same cycle as done[i] or aborted[i] for channel i SHALL be accepted.
REQ-013 Arbitration SHALL be round-robin from IDLE: when both are pending, the channel not granted last wins; after reset channel 0 has priority.
REQ-014 FSM states SHALL be IDLE, STOP, PER_L, PER_H, CLR, START, WAIT, ACK; each non-IDLE, non-WAIT state lasts exactly one cycle and issues exactly one write.
REQ-015 Writes, as (address, data): STOP (1, 0x0008); PER_L (2, P[15:0]); PER_H (3, P[31:16]); CLR (0, 0x0000); START (1, 0x0005); ACK (0, 0x0000); where P = delay - 1.
REQ-016 A write cycle SHALL drive tmr_chipselect=1 and tmr_write_n=0; in every other cycle chipselect=0, write_n=1, address=0, writedata=0.
REQ-017 Order SHALL be IDLE -> STOP -> PER_L -> PER_H -> CLR -> START -> WAIT; the first write occurs the cycle after a grant.
REQ-018 WAIT: tmr_irq=1 -> ACK; after the ACK write, done[g] pulses for one cycle, pending[g] clears, FSM returns to IDLE.
REQ-019 cancel[g] for the active channel in WAIT -> STOP write, then ACK write, then aborted[g] pulse and return to IDLE; done[g] SHALL NOT pulse.
REQ-020 tmr_irq and cancel[g] in the same WAIT cycle: irq SHALL win (done, not aborted).
REQ-021 cancel[i] for a pending, non-active channel SHALL clear pending[i] and pulse aborted[i] the next cycle, in any state.
REQ-022 cancel for the active channel outside WAIT, or for a non-pending channel, SHALL be ignored.
REQ-023 Grant-to-done latency SHALL be 6 write cycles plus the WAIT duration plus 1 cycle.
REQ-024 All done/aborted/rejected pulses SHALL be registered and one cycle wide; the two channels may pulse simultaneously.

Reset
REQ-025 While reset_n=0: FSM=IDLE, pending=0, delays=0, round-robin pointer selects channel 0, busy=0, all pulses=0, tmr_chipselect=0, tmr_write_n=1, tmr_address=0, tmr_writedata=0.
REQ-026 Reset asserted mid-sequence SHALL abandon the operation without further writes or pulses; timer state is not restored.

Verification
REQ-027 req[0], delay 10000 -> writes (1,0x0008), (2,0x270F), (3,0x0000), (0,0), (1,0x0005) on consecutive cycles; after the irq, the (0,0) write is followed by a one-cycle done[0] pulse.
REQ-028 req[0] and req[1] in the same cycle from reset, delays 100/200 -> ch0 served first (P=99), then ch1 (P=199); done[0] precedes done[1].
REQ-029 req_delay1 = 0 -> clamped to 1; writes P=0 to both period halves.
REQ-030 cancel[0] in WAIT -> (1,0x0008), (0,0), then aborted[0]; no done[0] pulse even if the irq rises afterwards.
REQ-031 ch0 active, ch1 pending, cancel[1] -> aborted[1] the next cycle; ch1 is never programmed; a second req[0] while pending -> rejected[0].
REQ-032 reset_n low during PER_H -> outputs are at reset values within the same cycle; no further writes.
